if_pc_redirect_ctrl: RTL
========================

# if_pc_redirect_ctrl

Fetch-stage PC sequencer that consumes the ID-stage branch handler's `br_prediction`, `branch_hazard_stall` and `flush` outputs. It is the other end of that protocol. Each cycle it selects the next fetch address, registers the IF/ID pipeline latch, and keeps a recovery address for the branch currently in ID. On a misprediction flush it redirects fetch to the recovery address and squashes the wrong-path instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset; synchronous, active-low.
- `imem_instr`  in  32: instruction word read at `pc_out` (same cycle).
- `br_prediction`  in  1: predict-taken for the branch in IF (already gated by stall upstream).
- `branch_hazard_stall`  in  1: hold IF and IF/ID.
- `load_use_stall`  in  1: hold IF and IF/ID (hazard unit).
- `flush`  in  1: the branch in ID was mispredicted.
- `pc_out`  out  32: current fetch address.
- `IFID_instr`  out  32: latched instruction.
- `IFID_pc_plus4`  out  32: latched PC+4.
- `IFID_valid`  out  1: latch holds a real instruction.
- `IFID_pred_taken`  out  1: prediction applied to the latched instruction.
- `redirect_count`  out  32: mispredict redirects (only with `IF_REDIRECT_CNT_EN`).
- `stall_count`  out  32: stalled cycles (only with `IF_REDIRECT_CNT_EN`).

## Operation
- Branch detect in IF: `imem_instr[31:26] == 6'b000100`.
- Target = `pc_out + 4 + {{14{imm[15]}}, imm, 2'b00}`, where `imm = imem_instr[15:0]`. All adds are 32-bit and wrap mod 2^32.
- `stall = branch_hazard_stall | load_use_stall`.
- States and transitions:
  - RUN: fetch proceeds.
  - HOLD: entered while `stall`=1; returns to RUN the cycle `stall` drops.
  - RECOVER: the single cycle after a flush edge; returns to RUN, or enters HOLD if `stall`=1.
- Next-PC priority, highest first:
  - reset → `RESET_PC`.
  - `flush` with `rec_valid`=1 → `rec_pc`.
  - `stall` → hold `pc_out`.
  - IF branch and `br_prediction`=1 → target.
  - Otherwise → `pc_out + 4`.
- IF/ID update, same priority:
  - flush → bubble: instr=0, valid=0, pred=0; pc_plus4 keeps its value.
  - stall → hold all fields.
  - Otherwise → load `imem_instr`, `pc_out+4`, valid=1, pred=`br_prediction & IF branch`.
- Recovery register (`rec_pc`, `rec_valid`):
  - Loads when a branch advances IF→IF/ID (no stall, no flush).
  - Loads `pc_out+4` if predicted taken, else the target; `rec_valid`=1.
  - A non-branch advancing clears `rec_valid`.
  - Flush clears `rec_valid`; stall holds it.
- `flush` with `rec_valid`=0 is a no-op: normal sequential or stall behaviour applies and it is not counted.
- `flush` and `stall` asserted together: flush wins and the PC redirects. Upstream gating normally prevents this case.
- `br_prediction` is ignored when IF holds no branch or when `stall`=1.

## Timing
- Reset values: `pc_out`=`RESET_PC`, all `IFID_*`=0, `rec_valid`=0, state=RUN, counters=0.
- All outputs are registered. Redirects take effect at the next rising edge.
- Predicted-taken branch: target fetched the cycle after the branch, with zero bubbles.
- Mispredict: exactly one bubble in IF/ID. The correct path enters IF/ID two edges after the flush cycle.
- Stall of N cycles: `pc_out` and IF/ID are frozen for exactly N edges.
- Reset mid-redirect or mid-stall: all state returns to reset values at that edge; no pending redirect survives.

## Configuration
- `IF_REDIRECT_CNT_EN`, when defined, instantiates two 32-bit saturating counters:
  - `redirect_count`: +1 per accepted flush.
  - `stall_count`: +1 per cycle with `stall`=1 and no flush.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the counters and both ports are absent, and no other behaviour changes.

## Test plan
- Reset, then sequential fetch with no branches → `pc_out` = 0, 4, 8, 12; `IFID_valid`=1 from the second edge.
- beq at PC 0x10 with imm=0x0003 and `br_prediction`=1 → next `pc_out`=0x20; `rec_pc`=0x14.
- That branch then gets `flush` in ID → next `pc_out`=0x14; IF/ID holds instr=0 and valid=0 for one cycle.
- beq at 0x40 with imm=0xFFFE, predicted not-taken, then `flush` → redirect to 0x3C. Also PC 0xFFFF_FFFC sequential → wraps to 0x0.
- `load_use_stall` high for 3 cycles at PC 0x80 → `pc_out` stays 0x80 and IF/ID is frozen; it resumes at 0x84. With macro: `stall_count`=3.
- `flush`=1 with `rec_valid`=0 → no redirect and `redirect_count` unchanged. `rst_n` low during RECOVER → `pc_out`=`RESET_PC` and all `IFID_*`=0 at the next edge.

Source files
------------

// File: rtl/if_pc_redirect_ctrl.sv
// Fetch-stage PC sequencer: next-PC selection, IF/ID latch and mispredict recovery.
// Define IF_REDIRECT_CNT_EN to add saturating redirect/stall counters.
module if_pc_redirect_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] imem_instr,
   input  logic        br_prediction,
   input  logic        branch_hazard_stall,
   input  logic        load_use_stall,
   input  logic        flush,
   output logic [31:0] pc_out,
   output logic [31:0] IFID_instr,
   output logic [31:0] IFID_pc_plus4,
   output logic        IFID_valid,
   output logic        IFID_pred_taken
`ifdef IF_REDIRECT_CNT_EN
   ,
   output logic [31:0] redirect_count,
   output logic [31:0] stall_count
`endif
);

   typedef enum logic [1:0] {
      RUN,
      HOLD,
      RECOVER
   } state_t;

   state_t      state;
   logic [31:0] rec_pc;
   logic        rec_valid;

   logic        is_branch;
   logic        stall;
   logic        flush_acc;
   logic        pred_taken;
   logic [31:0] pc_plus4;
   logic [31:0] target;

   assign is_branch  = (imem_instr[31:26] == 6'b000100);
   assign stall      = branch_hazard_stall | load_use_stall;
   // A flush only counts when a branch is actually waiting in ID.
   assign flush_acc  = flush & rec_valid;
   assign pred_taken = is_branch & br_prediction & ~stall;
   assign pc_plus4   = pc_out + 32'd4;
   assign target     = pc_plus4 + {{14{imem_instr[15]}}, imem_instr[15:0], 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= RUN;
         pc_out          <= RESET_PC;
         IFID_instr      <= 32'd0;
         IFID_pc_plus4   <= 32'd0;
         IFID_valid      <= 1'b0;
         IFID_pred_taken <= 1'b0;
         rec_pc          <= 32'd0;
         rec_valid       <= 1'b0;
      end else if (flush_acc) begin
         state           <= RECOVER;
         pc_out          <= rec_pc;
         IFID_instr      <= 32'd0;
         IFID_valid      <= 1'b0;
         IFID_pred_taken <= 1'b0;
         rec_valid       <= 1'b0;
      end else begin
         case (state)
            RUN, HOLD, RECOVER: state <= stall ? HOLD : RUN;
            default:            state <= RUN;
         endcase
         if (!stall) begin
            pc_out          <= pred_taken ? target : pc_plus4;
            IFID_instr      <= imem_instr;
            IFID_pc_plus4   <= pc_plus4;
            IFID_valid      <= 1'b1;
            IFID_pred_taken <= pred_taken;
            rec_valid       <= is_branch;
            // Recovery address is the path the prediction did not take.
            if (is_branch)
               rec_pc <= pred_taken ? pc_plus4 : target;
         end
      end
   end

`ifdef IF_REDIRECT_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         redirect_count <= 32'd0;
         stall_count    <= 32'd0;
      end else begin
         if (flush_acc && redirect_count != 32'hFFFF_FFFF)
            redirect_count <= redirect_count + 32'd1;
         if (stall && !flush_acc && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
